red_pitaya_fads_log_reader: RTL and testbench
=============================================

// Module: red_pitaya_fads_log_reader
// PURPOSE
//  Bus initiator that drains the FADS droplet logger over the system bus. On start it
//  reads N consecutive 32-bit logger words (LOG_BASE + 4*idx), waits for each sys_ack,
//  and presents every word on a valid/ready stream for the host-side acquisition path.
//  Detects missing acks (timeout) and bus errors, aborts cleanly and flags them.
// PARAMETERS
//  AW          4             log2 of logger entries; max burst = 2**AW
//  LOG_BASE    20'h10000     byte address of logger entry 0 in the FADS map
//  RD_SETUP    2             cycles sys_addr is held stable before sys_ren pulses
//  ACK_TO      15            max cycles waiting for sys_ack after sys_ren (>=1)
// PORTS
//  adc_clk_i   in   1    ADC clock, all logic rising-edge
//  adc_rst_i   in   1    reset, asynchronous, active-high
//  start_i     in   1    1-cycle pulse: begin drain (ignored while busy_o=1)
//  count_i     in   AW+1 entries to read, sampled on accepted start_i
//  busy_o      out  1    high from accepted start until done_o cycle inclusive
//  done_o      out  1    1-cycle pulse at end of drain (normal or aborted)
//  err_o       out  2    sticky: [0] ack timeout, [1] sys_err seen; cleared on start
//  sys_addr    out  32   bus address, {12'h0, LOG_BASE + 4*idx}
//  sys_wdata   out  32   constant 0
//  sys_sel     out  4    constant 4'hF
//  sys_wen     out  1    constant 0
//  sys_ren     out  1    read strobe, exactly 1 cycle per entry
//  sys_rdata   in   32   bus read data, valid with sys_ack
//  sys_err     in   1    bus error, qualified by sys_ack
//  sys_ack     in   1    bus acknowledge
//  m_data_o    out  32   logged word (droplet width)
//  m_valid_o   out  1    m_data_o valid; held until m_ready_i
//  m_ready_i   in   1    downstream accept
//  m_last_o    out  1    high with the final word of a burst
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, idx 0, err_o 0. Reset mid-burst aborts, no done_o.
//  States: IDLE -> SETUP -> REQ -> WAIT -> PUSH -> (SETUP | DONE) -> IDLE.
//  IDLE: start_i -> latch n=min(count_i, 2**AW), idx=0, err_o=0, busy_o=1;
//    n==0 -> DONE (no bus access); else SETUP. start_i while busy_o=1 is dropped.
//  SETUP: drive sys_addr for idx; after RD_SETUP cycles -> REQ. Address is held
//    unchanged from SETUP entry through WAIT exit (responder read path is registered).
//  REQ: sys_ren=1 for this one cycle only; -> WAIT with timer=0.
//  WAIT: sys_ack=1 & sys_err=0 -> capture sys_rdata into m_data_o, m_valid_o=1,
//    m_last_o=(idx==n-1), -> PUSH. sys_ack=1 & sys_err=1 -> err_o[1]=1, -> DONE.
//    No ack for ACK_TO cycles -> err_o[0]=1, -> DONE. Acks seen outside WAIT ignored.
//  PUSH: hold m_data_o/m_valid_o/m_last_o until m_valid_o&m_ready_i cycle;
//    then m_valid_o=0 next cycle; last -> DONE, else idx+1 -> SETUP.
//  DONE: done_o=1 one cycle, busy_o=1 this cycle, -> IDLE (busy_o=0 next).
//  idx is AW bits; n==2**AW reads every entry 0..2**AW-1, no wrap beyond.
//  Minimum per-entry latency REQ->m_valid_o: ack latency + 1 cycle.
//  Aborted burst never asserts m_last_o; partial words already pushed stand.
// TESTING
//  T1 count_i=4, responder acks 2 cycles after ren, data=idx+100, m_ready_i=1
//     -> reads 0x10000,04,08,0C; stream 100..103, m_last_o on 103; done_o; err_o=0.
//  T2 count_i=0 -> no sys_ren, done_o exactly 2 cycles after start_i, busy_o 2 cycles.
//  T3 count_i=31 with AW=4 -> exactly 16 reads 0x10000..0x1003C, last on entry 15.
//  T4 responder never acks entry 2 -> err_o=2'b01 after ACK_TO cycles, 2 words out,
//     no m_last_o, done_o; next start_i clears err_o.
//  T5 m_ready_i low 10 cycles on word 1 -> m_data_o stable, no sys_ren until accepted;
//     start_i pulsed during burst ignored.
//  T6 adc_rst_i asserted in WAIT -> outputs 0 immediately, no done_o; new start works.

Source files
------------

// File: rtl/red_pitaya_fads_log_reader_if.sv
// Signal bundle of the FADS log reader: control, system-bus initiator side
// and the downstream word stream. master = the reader, slave = its environment.
interface red_pitaya_fads_log_reader_if #(
    parameter int unsigned AW = 4
);
    logic          start_i;
    logic [AW:0]   count_i;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    err_o;

    logic [31:0]   sys_addr;
    logic [31:0]   sys_wdata;
    logic [3:0]    sys_sel;
    logic          sys_wen;
    logic          sys_ren;
    logic [31:0]   sys_rdata;
    logic          sys_err;
    logic          sys_ack;

    logic [31:0]   m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          m_last_o;

    modport master (
        input  start_i, count_i, sys_rdata, sys_err, sys_ack, m_ready_i,
        output busy_o, done_o, err_o, sys_addr, sys_wdata, sys_sel, sys_wen,
               sys_ren, m_data_o, m_valid_o, m_last_o
    );

    modport slave (
        output start_i, count_i, sys_rdata, sys_err, sys_ack, m_ready_i,
        input  busy_o, done_o, err_o, sys_addr, sys_wdata, sys_sel, sys_wen,
               sys_ren, m_data_o, m_valid_o, m_last_o
    );
endinterface

// File: rtl/red_pitaya_fads_log_reader.sv
// FADS droplet-log drain: reads N consecutive logger words over the system bus
// and forwards each on a valid/ready stream, aborting on ack timeout or bus error.
//
// state | meaning
// IDLE  | waiting for an accepted start_i
// SETUP | address driven, settling for RD_SETUP cycles
// REQ   | single-cycle read strobe
// WAIT  | waiting up to ACK_TO cycles for sys_ack
// PUSH  | word presented until accepted downstream
// DONE  | drain finished or aborted; done_o pulses on the following cycle
module red_pitaya_fads_log_reader #(
    parameter int unsigned AW       = 4,
    parameter logic [19:0] LOG_BASE = 20'h10000,
    parameter int unsigned RD_SETUP = 2,
    parameter int unsigned ACK_TO   = 15
) (
    input logic                          adc_clk_i,
    input logic                          adc_rst_i,
    red_pitaya_fads_log_reader_if.master bus
);
    localparam int unsigned   TW         = $clog2(RD_SETUP + ACK_TO + 1);
    localparam logic [AW:0]   N_MAX      = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   N_ONE      = {{AW{1'b0}}, 1'b1};
    localparam logic [TW-1:0] SETUP_LOAD = TW'(RD_SETUP - 1);
    localparam logic [TW-1:0] ACK_LOAD   = TW'(ACK_TO - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        WAIT,
        PUSH,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [AW:0]   count_in;
    logic [AW:0]   count_clip;
    logic [AW:0]   n_q;
    logic [AW-1:0] idx_q;
    logic [TW-1:0] timer_q;
    logic [31:0]   data_q;
    logic          valid_q;
    logic          last_q;
    logic          busy_q;
    logic          done_q;
    logic [1:0]    err_q;

    logic          start_ok;
    logic          ack_ok;
    logic          ack_bad;
    logic          timeout;
    logic          handshake;
    logic          is_last;
    logic          addr_live;

    assign count_in   = bus.count_i;
    assign count_clip = (count_in > N_MAX) ? N_MAX : count_in;

    // busy_q stays high through the done_o cycle, so a start there is dropped too
    assign start_ok  = (state == IDLE) && bus.start_i && !busy_q;
    assign ack_ok    = (state == WAIT) && bus.sys_ack && !bus.sys_err;
    assign ack_bad   = (state == WAIT) && bus.sys_ack && bus.sys_err;
    assign timeout   = (state == WAIT) && !bus.sys_ack && (timer_q == '0);
    assign handshake = (state == PUSH) && valid_q && bus.m_ready_i;
    assign is_last   = ({1'b0, idx_q} == (n_q - N_ONE));

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = (count_clip == '0) ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (timer_q == '0) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (ack_ok) begin
                    state_next = PUSH;
                end else if (ack_bad || timeout) begin
                    state_next = DONE;
                end
            end
            PUSH: begin
                if (handshake) begin
                    state_next = last_q ? DONE : SETUP;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            n_q     <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            busy_q <= (state_next != IDLE) || (state == DONE);
            done_q <= (state == DONE);

            if (start_ok) begin
                n_q   <= count_clip;
                idx_q <= '0;
                err_q <= '0;
            end

            // one down-counter serves both the address settle and the ack timeout
            if ((state_next == SETUP) && (state != SETUP)) begin
                timer_q <= SETUP_LOAD;
            end else if (state == REQ) begin
                timer_q <= ACK_LOAD;
            end else if (timer_q != '0) begin
                timer_q <= timer_q - TW'(1);
            end

            if (ack_ok) begin
                data_q  <= bus.sys_rdata;
                valid_q <= 1'b1;
                last_q  <= is_last;
            end
            if (ack_bad) begin
                err_q[1] <= 1'b1;
            end
            if (timeout) begin
                err_q[0] <= 1'b1;
            end

            if (handshake) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                if (!last_q) begin
                    idx_q <= idx_q + AW'(1);
                end
            end
        end
    end

    // idx_q only moves on the PUSH->SETUP edge, so the address is steady SETUP..WAIT
    assign addr_live = (state == SETUP) || (state == REQ) || (state == WAIT);

    assign bus.sys_addr  = addr_live ? {12'h000, LOG_BASE + 20'({idx_q, 2'b00})} : 32'h0;
    assign bus.sys_wdata = 32'h0;
    assign bus.sys_sel   = 4'hF;
    assign bus.sys_wen   = 1'b0;
    assign bus.sys_ren   = (state == REQ);

    assign bus.m_data_o  = data_q;
    assign bus.m_valid_o = valid_q;
    assign bus.m_last_o  = last_q;

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
endmodule

// File: tb/tb_red_pitaya_fads_log_reader.sv
// Randomized bench for the FADS log reader: a latency-programmable bus responder,
// a stalling stream sink and a per-burst reference of expected reads/words/errors.
module tb_red_pitaya_fads_log_reader;
    localparam int          AW       = 4;
    localparam int          NMAX     = 1 << AW;
    localparam int          RD_SETUP = 2;
    localparam int          ACK_TO   = 15;
    localparam int          NEVER    = 1000;
    localparam logic [31:0] BASE     = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    red_pitaya_fads_log_reader_if #(.AW(AW)) bus ();

    red_pitaya_fads_log_reader #(
        .AW       (AW),
        .LOG_BASE (20'h10000),
        .RD_SETUP (RD_SETUP),
        .ACK_TO   (ACK_TO)
    ) dut (
        .adc_clk_i (clk),
        .adc_rst_i (rst),
        .bus       (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // per-entry responder behaviour for the current burst
    logic [31:0] mem  [NMAX];
    int          lat  [NMAX];
    bit          berr [NMAX];

    logic [31:0] ren_addr_q [$];
    logic [32:0] word_q     [$];
    int          done_cnt   = 0;
    int          ready_pct  = 100;
    int          stall_idx  = -1;
    int          stall_left = 0;

    // bus responder: ack lat[e] cycles after the read strobe, data looked up at ack time
    initial begin
        int w;
        int ei;
        bus.sys_ack   = 1'b0;
        bus.sys_err   = 1'b0;
        bus.sys_rdata = '0;
        forever begin
            @(negedge clk);
            bus.sys_ack   = 1'b0;
            bus.sys_rdata = $urandom;
            bus.sys_err   = 1'($urandom_range(0, 1));
            if (bus.sys_ren === 1'b1) begin
                ei = int'((bus.sys_addr - BASE) >> 2);
                w  = (ei >= 0 && ei < NMAX) ? lat[ei] : 1;
                if (w < NEVER) begin
                    for (int j = 1; j < w; j++) begin
                        @(negedge clk);
                        bus.sys_rdata = $urandom;
                        bus.sys_err   = 1'($urandom_range(0, 1));
                    end
                    @(negedge clk);
                    ei = int'((bus.sys_addr - BASE) >> 2);
                    bus.sys_ack   = 1'b1;
                    bus.sys_rdata = (ei >= 0 && ei < NMAX) ? mem[ei] : 32'hDEAD_BEEF;
                    bus.sys_err   = (ei >= 0 && ei < NMAX) ? berr[ei] : 1'b0;
                end
            end
        end
    end

    // stream sink with optional stall on one word
    initial begin
        logic        hold_pend;
        logic [32:0] hold_word;
        hold_pend     = 1'b0;
        hold_word     = '0;
        bus.m_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_pend && !rst) begin
                check_eq("stream_hold", {bus.m_valid_o, bus.m_last_o, bus.m_data_o}, {1'b1, hold_word});
            end
            if (bus.m_valid_o && stall_left > 0 && word_q.size() == stall_idx) begin
                bus.m_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus.m_ready_i = (int'($urandom_range(0, 99)) < ready_pct);
            end
            if (bus.m_valid_o && bus.m_ready_i) begin
                word_q.push_back({bus.m_last_o, bus.m_data_o});
            end
            hold_pend = bus.m_valid_o && !bus.m_ready_i;
            hold_word = {bus.m_last_o, bus.m_data_o};
        end
    end

    // bus-side monitor
    initial begin
        logic        prev_ren;
        logic [31:0] prev_addr;
        prev_ren  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (bus.sys_ren === 1'b1) begin
                ren_addr_q.push_back(bus.sys_addr);
                check_eq("ren_pulse", prev_ren, 1'b0);
                check_eq("addr_setup", prev_addr, bus.sys_addr);
                check_eq("ren_vs_valid", bus.m_valid_o, 1'b0);
                check_eq("bus_const", {bus.sys_wen, bus.sys_sel, bus.sys_wdata}, {1'b0, 4'hF, 32'h0});
            end
            if (bus.done_o === 1'b1) done_cnt++;
            prev_ren  = bus.sys_ren;
            prev_addr = bus.sys_addr;
        end
    end

    // plan: 0 clean, 1 entry never acked, 2 entry acked too late, 3 bus error on entry
    task automatic run_burst(input int cnt, input int plan, input int fail_idx, input int fixed_lat,
                             input bit seq_data, input int rdy, input int stall_w, input bit poke);
        int          n;
        int          k;
        int          fail_at;
        int          exp_err;
        bit          seen;
        logic [31:0] exp_addr [$];
        logic [32:0] exp_word [$];

        n = (cnt > NMAX) ? NMAX : cnt;
        for (int i = 0; i < NMAX; i++) begin
            mem[i]  = seq_data ? 32'(100 + i) : $urandom;
            lat[i]  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, ACK_TO));
            berr[i] = 1'b0;
        end
        fail_at = (fail_idx >= 0) ? fail_idx : ((n > 0) ? int'($urandom_range(0, n - 1)) : 0);
        if (plan != 0 && fail_at < n) begin
            if (plan == 1) lat[fail_at] = NEVER;
            else if (plan == 2) lat[fail_at] = ACK_TO + int'($urandom_range(1, 3));
            else berr[fail_at] = 1'b1;
        end

        exp_err = 0;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            if (lat[i] > ACK_TO) begin
                exp_err = 1;
                break;
            end
            if (berr[i]) begin
                exp_err = 2;
                break;
            end
            exp_word.push_back({(i == n - 1), mem[i]});
        end

        ready_pct  = rdy;
        stall_idx  = stall_w;
        stall_left = 10;
        ren_addr_q.delete();
        word_q.delete();
        done_cnt = 0;

        @(negedge clk);
        bus.start_i = 1'b1;
        bus.count_i = (AW + 1)'(cnt);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.count_i = (AW + 1)'($urandom);
        check_eq("busy_at_start", bus.busy_o, 1'b1);
        check_eq("err_cleared", bus.err_o, 2'b00);

        k    = 1;
        seen = 1'b0;
        while (!seen && k < 3000) begin
            if (bus.done_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                bus.start_i = poke && (k == 7);
                if (poke && k == 7) bus.count_i = (AW + 1)'($urandom_range(1, 31));
                @(negedge clk);
                k++;
            end
        end
        bus.start_i = 1'b0;
        check_eq("done_seen", seen, 1'b1);
        if (n == 0) check_eq("zero_done_lat", k, 2);
        check_eq("busy_in_done", bus.busy_o, 1'b1);
        check_eq("err_at_done", bus.err_o, exp_err);

        // a start in the done_o cycle must be dropped as well
        if (poke) begin
            bus.start_i = 1'b1;
            bus.count_i = (AW + 1)'(5);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        check_eq("busy_after_done", bus.busy_o, 1'b0);
        repeat (ACK_TO + 6) @(negedge clk);
        check_eq("idle_stays", bus.busy_o, 1'b0);
        check_eq("err_sticky", bus.err_o, exp_err);
        check_eq("single_done", done_cnt, 1);

        check_eq("ren_count", ren_addr_q.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < ren_addr_q.size(); i++) begin
            check_eq("ren_addr", ren_addr_q[i], exp_addr[i]);
        end
        check_eq("word_count", word_q.size(), exp_word.size());
        for (int i = 0; i < exp_word.size() && i < word_q.size(); i++) begin
            check_eq("word", word_q[i], exp_word[i]);
        end
    endtask

    task automatic reset_mid_wait();
        int k;
        for (int i = 0; i < NMAX; i++) begin
            mem[i]  = $urandom | 32'h1;
            lat[i]  = 10;
            berr[i] = 1'b0;
        end
        ready_pct = 100;
        stall_idx = -1;
        ren_addr_q.delete();
        word_q.delete();
        done_cnt = 0;

        @(negedge clk);
        bus.start_i = 1'b1;
        bus.count_i = (AW + 1)'(8);
        @(negedge clk);
        bus.start_i = 1'b0;
        k = 0;
        while (ren_addr_q.size() < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_reach_wait", ren_addr_q.size(), 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_ctrl", {bus.busy_o, bus.done_o, bus.err_o, bus.sys_ren, bus.m_valid_o, bus.m_last_o}, 7'h0);
        check_eq("rst_mid_data", {bus.sys_addr, bus.m_data_o}, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (ACK_TO + 6) @(negedge clk);
        check_eq("rst_no_done", done_cnt, 0);
        check_eq("rst_idle", {bus.busy_o, bus.m_valid_o, bus.err_o}, 4'h0);
        check_eq("rst_words", word_q.size(), 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start_i = 1'b0;
        bus.count_i = '0;
        for (int i = 0; i < NMAX; i++) begin
            mem[i]  = '0;
            lat[i]  = 1;
            berr[i] = 1'b0;
        end
        #1;
        check_eq("rst_ctrl", {bus.busy_o, bus.done_o, bus.err_o, bus.sys_ren, bus.m_valid_o, bus.m_last_o, bus.sys_wen}, 8'h0);
        check_eq("rst_data", {bus.sys_addr, bus.m_data_o}, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_burst(4, 0, -1, 2, 1'b1, 100, -1, 1'b0);   // sequential data 100..103
        run_burst(0, 0, -1, 0, 1'b0, 100, -1, 1'b0);   // empty drain
        run_burst(31, 0, -1, 0, 1'b0, 100, -1, 1'b0);  // clipped to 16 entries
        run_burst(4, 1, 2, 2, 1'b0, 100, -1, 1'b0);    // entry 2 never acked
        run_burst(5, 0, -1, 2, 1'b0, 100, 1, 1'b1);    // stall on word 1, stray starts
        run_burst(6, 3, 3, 0, 1'b0, 80, -1, 1'b0);     // bus error on entry 3
        run_burst(6, 2, 0, 0, 1'b0, 80, -1, 1'b0);     // first ack arrives too late
        run_burst(16, 0, -1, ACK_TO, 1'b0, 60, -1, 1'b0);
        reset_mid_wait();
        run_burst(3, 0, -1, 0, 1'b0, 100, -1, 1'b0);

        for (int r = 0; r < 30; r++) begin
            int pl;
            int sw;
            pl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            sw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_burst(int'($urandom_range(0, 31)), pl, -1, 0, 1'b0,
                      int'($urandom_range(30, 100)), sw, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
